// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch buffer.
package fetch_pkg;
    typedef logic [31:0] word_t;
    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, inst} entries with push/pop/flush and occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: credit-based instruction prefetch with redirect flush.
// Define FETCH_MISALIGN_EN to flag misaligned redirects instead of masking them.
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_misalign
);
    localparam int CW = $clog2(DEPTH + 1);
    word_t         pc, rsp_pc, redir_tgt;
    logic [CW-1:0] outstanding, discard, occ, out_next;
    logic          acc, rsp_ok, push, pop, full, empty, misalign;
    fetch_entry_t  head;
`ifdef FETCH_MISALIGN_EN
    assign redir_tgt = redirect_pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else if (redirect_valid) misalign <= |redirect_pc[1:0];
    end
`else
    assign redir_tgt = redirect_pc & ~32'h3;
    assign misalign  = 1'b0;
`endif
    assign fetch_misalign = misalign;
    // one credit per slot: every in-flight request must find room in the FIFO
    assign imem_req_valid = rst_n && !misalign && !full &&
                            (({1'b0, outstanding} + {1'b0, occ}) < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign acc            = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_ok && (discard == '0) && !redirect_valid;
    assign pop            = !empty && inst_ready;
    assign out_next       = outstanding + CW'(acc) - CW'(rsp_ok);
    assign inst_valid     = !empty;
    assign inst_code      = head.inst;
    assign inst_pc        = head.pc;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: rsp_pc, inst: imem_rsp_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );
    // rsp_pc follows the oldest live request; stale ones are skipped via discard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                pc      <= redir_tgt;
                rsp_pc  <= redir_tgt;
                discard <= out_next;
            end else begin
                if (acc) pc <= pc + 32'd4;
                if (push) rsp_pc <= rsp_pc + 32'd4;
                if (rsp_ok && discard != '0) discard <= discard - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed and random checks against a queue-based fetch model.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_code, inst_pc;
    logic        fetch_misalign;

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    req_t        memq[$];
    ent_t        exp_q[$];
    logic [31:0] acc_log[$], pop_log[$];
    logic [31:0] m_pc = '0;
    logic        m_mis = 1'b0;
    int          ready_mode = 0, rsp_mode = 0, ir_mode = 0;
    int          n_chk = 0, n_fail = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        logic m_rv, acc, rsp, pop, redir;
        logic [31:0] rdata, rpc;
        req_t r;
        @(negedge clk);
        m_rv = rst_n && !m_mis && (memq.size() + exp_q.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(m_rv));
        if (m_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("inst_pc", inst_pc, exp_q[0].pc);
            chk("inst_code", inst_code, exp_q[0].inst);
        end
        if (!rst_n) begin
            chk("rst_code", inst_code, 32'h0);
            chk("rst_pc", inst_pc, 32'h0);
        end
        chk("misalign", 32'(fetch_misalign), 32'(m_mis));
        acc   = m_rv && imem_req_ready;
        rsp   = imem_rsp_valid && memq.size() != 0;
        pop   = exp_q.size() != 0 && inst_ready;
        redir = redirect_valid;
        rdata = imem_rsp_data;
        rpc   = redirect_pc;
        @(posedge clk);
        if (rst_n) begin
            if (pop && !redir) begin
                pop_log.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
            end
            if (rsp) begin
                r = memq.pop_front();
                if (r.live && !redir) exp_q.push_back('{r.addr, rdata});
            end
            if (acc) begin
                acc_log.push_back(m_pc);
                memq.push_back('{m_pc, 1'b1});
            end
            if (redir) begin
                exp_q.delete();
                foreach (memq[i]) memq[i].live = 1'b0;
`ifdef FETCH_MISALIGN_EN
                m_pc  = rpc;
                m_mis = |rpc[1:0];
`else
                m_pc  = rpc & ~32'h3;
`endif
            end else if (acc) m_pc = m_pc + 32'd4;
        end
        #1;
        imem_req_ready = ready_mode == 2 ? 1'($urandom % 2) : ready_mode[0];
        if (rst_n && memq.size() != 0 && (rsp_mode == 1 || (rsp_mode == 2 && $urandom % 2 == 0))) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(memq[0].addr);
        end else if (rst_n && memq.size() == 0 && rsp_mode == 2 && $urandom % 4 == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        if (ir_mode == 2) inst_ready = 1'($urandom % 2);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int start, idx;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst_n = 1'b1;
        ready_mode = 1;
        rsp_mode = 1;
        inst_ready = 1'b1;
        repeat (10) cycle();
        chk("seq_addr0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_DEAD, 32'h0);
        chk("seq_addr1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_DEAD, 32'h4);
        chk("seq_addr2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_DEAD, 32'h8);
        chk("seq_pc2", pop_log.size() > 2 ? pop_log[2] : 32'hDEAD_DEAD, 32'h8);

        inst_ready = 1'b0;
        repeat (8) cycle();
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_inst_valid", 32'(inst_valid), 32'h1);
        start = acc_log.size();
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        repeat (6) cycle();
        chk("one_refill", 32'(acc_log.size() - start), 32'h1);

        rsp_mode = 0;
        inst_ready = 1'b1;
        repeat (5) cycle();
        chk("two_outstanding", 32'(memq.size()), 32'h2);
        redirect(32'h100);
        rsp_mode = 1;
        start = pop_log.size();
        repeat (8) cycle();
        chk("redir_first_pc", pop_log.size() > start ? pop_log[start] : 32'hDEAD_DEAD, 32'h100);

        redirect(32'hFFFF_FFF8);
        start = acc_log.size();
        repeat (10) cycle();
        idx = -1;
        for (int i = start; i < acc_log.size() - 1; i++)
            if (acc_log[i] == 32'hFFFF_FFFC) idx = i;
        chk("pc_wrap", idx >= 0 ? acc_log[idx + 1] : 32'hDEAD_DEAD, 32'h0);

        redirect(32'h102);
        start = acc_log.size();
        repeat (6) cycle();
`ifdef FETCH_MISALIGN_EN
        chk("misalign_flag", 32'(fetch_misalign), 32'h1);
        chk("misalign_no_req", 32'(acc_log.size() - start), 32'h0);
        redirect(32'h200);
        repeat (4) cycle();
        chk("misalign_clear", 32'(fetch_misalign), 32'h0);
`else
        chk("masked_redirect", acc_log.size() > start ? acc_log[start] : 32'hDEAD_DEAD, 32'h100);
`endif

        ready_mode = 2;
        rsp_mode = 2;
        ir_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 16 == 0) begin
`ifdef FETCH_MISALIGN_EN
                redirect($urandom & ~32'h3);
`else
                redirect($urandom);
`endif
            end else cycle();
        end

        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("arst_inst_valid", 32'(inst_valid), 32'h0);
        chk("arst_inst_code", inst_code, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_misalign", 32'(fetch_misalign), 32'h0);
        chk("arst_req_addr", imem_req_addr, 32'h0);
        memq.delete();
        exp_q.delete();
        m_pc = 32'h0;
        m_mis = 1'b0;
        imem_rsp_valid = 1'b0;
        ready_mode = 1;
        rsp_mode = 1;
        ir_mode = 0;
        inst_ready = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        start = acc_log.size();
        repeat (8) cycle();
        chk("restart_addr", acc_log.size() > start ? acc_log[start] : 32'hDEAD_DEAD, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, prefetch FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_addr  output  32  fetch byte address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port inst_valid  output  1  instruction available to decode/immediate generation.
REQ-013 SHALL have port inst_code  output  32  instruction word to decode.
REQ-014 SHALL have port inst_pc  output  32  address of inst_code.
REQ-015 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-016 SHALL have port fetch_misalign  output  1  misaligned redirect flag.

Function
REQ-017 SHALL hold fetch PC; request accepted on imem_req_valid && imem_req_ready -> PC += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 SHALL drive imem_req_addr = PC; addr SHALL stay stable while valid && !ready, except on redirect.
REQ-019 SHALL assert imem_req_valid only when outstanding + FIFO occupancy < DEPTH (credit rule); FIFO therefore never overflows.
REQ-020 SHALL count outstanding requests: +1 on accept, -1 on response, both same cycle = unchanged; width clog2(DEPTH+1).
REQ-021 SHALL push {PC of that request, imem_rsp_data} into FIFO on imem_rsp_valid unless the response is being discarded.
REQ-022 SHALL have inst_valid = FIFO non-empty; inst_code/inst_pc = head entry; pop on inst_valid && inst_ready.
REQ-023 SHALL have minimum latency 1 cycle from imem_rsp_valid to inst_valid; no combinational bypass.
REQ-024 SHALL support push and pop in one cycle with occupancy unchanged.
REQ-025 SHALL, on redirect_valid: PC <= redirect_pc, FIFO flushed, in-flight responses marked for discard (discard count <= outstanding net of any response that cycle); redirect wins over a same-cycle accept, push or pop.
REQ-026 SHALL drop responses while discard count > 0, decrementing per response.
REQ-027 SHALL ignore imem_rsp_valid when outstanding = 0.

Reset
REQ-028 SHALL, while rst_n low: PC = RESET_PC, FIFO empty, outstanding = 0, discard = 0, imem_req_valid = 0, inst_valid = 0, inst_code = 0, inst_pc = 0, fetch_misalign = 0.
REQ-029 SHALL abort all in-flight requests on reset mid-operation; first request at RESET_PC in first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, with FETCH_MISALIGN_EN defined: redirect_pc[1:0] != 0 sets fetch_misalign (sticky), suppresses requests until the next aligned redirect clears it.
REQ-031 SHALL, without FETCH_MISALIGN_EN: redirect_pc[1:0] forced to 0 and fetch_misalign tied 0.

Structure
REQ-032 SHALL place word_t (32-bit), fifo entry struct {pc, inst}, and default RESET_PC constant in shared package fetch_pkg.
REQ-033 SHALL implement FIFO as sub-module fetch_fifo (DEPTH, push/pop/flush, full/empty, occupancy).

Verification
REQ-034 SHALL cover reset then ready = 1, 1-cycle memory: addrs 0x0, 0x4, 0x8; inst_pc tracks; inst_code = returned words.
REQ-035 SHALL cover inst_ready = 0 with DEPTH = 2: after 2 entries imem_req_valid = 0; one pop re-enables exactly one request.
REQ-036 SHALL cover redirect to 0x100 with 2 outstanding: both stale responses dropped, next inst_pc = 0x100.
REQ-037 SHALL cover PC = 0xFFFF_FFFC accepted: next imem_req_addr = 0x0.
REQ-038 SHALL cover redirect to 0x102: with FETCH_MISALIGN_EN fetch_misalign = 1 and no requests; without it next addr = 0x100.
REQ-039 SHALL cover rst_n asserted mid-stream: all outputs 0 asynchronously, restart at RESET_PC.
